fp_mult_pipe: RTL
=================

# fp_mult_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier: next generation of the lab's single-precision `fp_mult`. Accepts one operand pair per cycle under a valid/ready handshake and produces the packed product 3 cycles later. Supports a per-operation rounding mode and IEEE exception flags. Sits between the operand source (register file or testbench driver) and the result sink.

## Interface
- `EXP_W`, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, 23: stored fraction width (hidden bit excluded); word width W = 1+EXP_W+MAN_W.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: block accepts the pair this cycle.
- `a`, `b` in W: operands, sign|exp|frac.
- `rnd_mode` in 1: 0 = round-to-nearest-even (RNE), 1 = round-toward-zero (RTZ); travels with its operands.
- `out_valid` out 1: result present.
- `out_ready` in 1: sink takes result this cycle.
- `y` out W: product.
- `flags` out 4: {invalid, overflow, underflow, inexact}, qualified by `out_valid`.

## Operation
- Transfer occurs on a cycle where valid and ready are both high, on each side.
- Global advance: `adv = !out_valid || out_ready`; `in_ready = adv`. When `adv` is low, all stages hold. Bubbles are not compressed.
- Stage 1 (unpack): classify each operand as ZERO (exp=0, including denormals, flushed to zero), INF, NAN, or NORM. Sign = sa^sb. Biased exponent sum = ea+eb-bias, computed at EXP_W+2 signed width.
- Stage 2 (multiply): (1.fa)×(1.fb) gives a 2·MAN_W+2 bit product.
- Stage 3 (normalise/round/pack):
  - If product bit [2·MAN_W+1] is set, shift right 1 and increment the exponent.
  - Guard = first dropped bit; sticky = OR of the rest.
  - RNE increments when guard && (sticky || lsb). RTZ never increments.
  - A mantissa carry-out from rounding increments the exponent.
- Special results, in priority order:
  - NaN operand, or INF×ZERO: canonical qNaN (sign 0, exp all-ones, frac MSB 1), invalid=1.
  - INF operand: signed INF.
  - ZERO operand: signed zero, no flags.
- Overflow (final exp ≥ all-ones): RNE gives signed INF, RTZ gives signed max finite. Sets overflow=1 and inexact=1.
- Underflow (final exp ≤ 0): signed zero (FTZ), underflow=1, inexact=1.
- inexact = guard || sticky for normal results.

## Timing
- Latency is 3 cycles from input transfer to `out_valid`, with no stalls. Throughput is 1 per cycle.
- A result held under `out_ready=0` keeps `y`/`flags` stable until transferred.
- Reset: all stage-valid bits, `out_valid`, `y`, and `flags` are 0; `in_ready` is 1.
- Reset mid-operation discards in-flight operations. The first `out_valid` after reset occurs 3 cycles after the first post-reset transfer.
- Simultaneous output transfer and input transfer in the same cycle is legal and sustains full throughput.
- `rnd_mode` is sampled only on input transfer.

## Structure
- Package `fp_pkg`:
  - class enum {ZERO, NORM, INF, NAN};
  - flag index constants;
  - functions for bias, all-ones exponent, canonical qNaN, and max finite, each in terms of EXP_W/MAN_W.
- Sub-module `fp_round_pack`: combinational stage-3 logic (normalise, round, overflow/underflow, pack, flags), reusable by a future adder.
- Top level holds the three pipeline registers and the handshake.

## Test plan
- Default params, RNE: a=0x3F800000, b=0x3F800000 → y=0x3F800000, flags=0, exactly 3 cycles after transfer. Then 0x40000000×0x40400000 → 0x40C00000.
- Rounding: 0x3FC00001×0x3FC00001 → RNE 0x40100002 and RTZ 0x40100001, both inexact=1.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000×0x40000000 → 0xFF800000.
  - 0x80000000×0x3F800000 → 0x80000000.
- Range:
  - 0x7F7FFFFF×0x40000000 → RNE 0x7F800000, RTZ 0x7F7FFFFF, overflow+inexact.
  - 0x00800000×0x3F000000 → 0x00000000, underflow+inexact.
- Back-pressure: stream 8 back-to-back ops and hold `out_ready`=0 for 5 cycles mid-stream → `in_ready` drops, no result lost or duplicated, and order is preserved. Assert `rst_n`=0 for one cycle mid-stream → `out_valid`=0 and nothing emitted until new input.
- Parametrised half precision: EXP_W=5, MAN_W=10, 0x3C00×0x4000 → 0x4000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and format helpers for the pipelined FP multiplier.
// Helpers are sized to 64 bits; callers cast down to their word width.
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

  localparam int FLG_W   = 4;
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic logic [63:0] fp_bias(int ew);
    return (64'd1 << (ew - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fp_all_ones(int ew);
    return (64'd1 << ew) - 64'd1;
  endfunction

  function automatic logic [63:0] fp_qnan(int ew, int mw);
    return (fp_all_ones(ew) << mw) | (64'd1 << (mw - 1));
  endfunction

  function automatic logic [63:0] fp_max_fin(int ew, int mw);
    return ((fp_all_ones(ew) - 64'd1) << mw)
         | ((64'd1 << mw) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round, range-check and pack a raw mantissa product.
// Purely combinational so an adder datapath can share it.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [2*MAN_W+1:0]   i_prod,
  input  logic [EXP_W+1:0]     i_exp,
  input  logic                 i_sign,
  input  logic                 i_rnd,
  input  fp_class_e            i_kind,
  output logic [EXP_W+MAN_W:0] o_y,
  output logic [FLG_W-1:0]     o_flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int PW  = 2 * MAN_W + 2;
  localparam int EW2 = EXP_W + 2;

  localparam logic [W-1:0]   QNAN = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0]   MAXF = W'(fp_max_fin(EXP_W, MAN_W));
  localparam logic [EW2-1:0] MAXE = EW2'(fp_all_ones(EXP_W));
  localparam logic [EW2-1:0] ONE  = EW2'(1);

  logic               w_g;
  logic               w_st;
  logic               w_inc;
  logic               w_ovf;
  logic               w_unf;
  logic [MAN_W:0]     w_mant;
  logic [MAN_W+1:0]   w_mr;
  logic [MAN_W-1:0]   w_frac;
  logic [EW2-1:0]     w_en;
  logic [EW2-1:0]     w_ef;

  always_comb begin
    if (i_prod[PW-1]) begin
      w_mant = i_prod[PW-1:MAN_W+1];
      w_g    = i_prod[MAN_W];
      w_st   = |i_prod[MAN_W-1:0];
      w_en   = i_exp + ONE;
    end else begin
      w_mant = i_prod[PW-2:MAN_W];
      w_g    = i_prod[MAN_W-1];
      w_st   = |i_prod[MAN_W-2:0];
      w_en   = i_exp;
    end
  end

  assign w_inc = !i_rnd && w_g && (w_st || w_mant[0]);
  assign w_mr  = {1'b0, w_mant}
               + {{(MAN_W+1){1'b0}}, w_inc};

  // Rounding carry-out leaves an all-zero fraction one binade up.
  always_comb begin
    if (w_mr[MAN_W+1]) begin
      w_frac = w_mr[MAN_W:1];
      w_ef   = w_en + ONE;
    end else begin
      w_frac = w_mr[MAN_W-1:0];
      w_ef   = w_en;
    end
  end

  assign w_ovf = !w_ef[EW2-1] && (w_ef >= MAXE);
  assign w_unf = w_ef[EW2-1] || (w_ef == '0);

  always_comb begin
    o_y     = '0;
    o_flags = '0;
    unique case (i_kind)
      NAN: begin
        o_y              = QNAN;
        o_flags[FLG_INV] = 1'b1;
      end
      INF: begin
        o_y = {i_sign, MAXE[EXP_W-1:0], {MAN_W{1'b0}}};
      end
      ZERO: begin
        o_y = {i_sign, {(W-1){1'b0}}};
      end
      default: begin
        if (w_ovf) begin
          o_y = i_rnd ? {i_sign, MAXF[W-2:0]}
                      : {i_sign, MAXE[EXP_W-1:0], {MAN_W{1'b0}}};
          o_flags[FLG_OVF] = 1'b1;
          o_flags[FLG_INX] = 1'b1;
        end else if (w_unf) begin
          o_y              = {i_sign, {(W-1){1'b0}}};
          o_flags[FLG_UNF] = 1'b1;
          o_flags[FLG_INX] = 1'b1;
        end else begin
          o_y              = {i_sign, w_ef[EXP_W-1:0], w_frac};
          o_flags[FLG_INX] = w_g || w_st;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with global stall.
// Stages: unpack/classify, mantissa multiply, round/pack.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 rnd_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y,
  output logic [FLG_W-1:0]     flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int PW  = 2 * MAN_W + 2;
  localparam int EW2 = EXP_W + 2;

  localparam logic [EW2-1:0] BIAS = EW2'(fp_bias(EXP_W));

  function automatic fp_class_e cls_of(
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] f
  );
    if (e == '0)      return ZERO;
    else if (e != '1) return NORM;
    else if (f == '0) return INF;
    else              return NAN;
  endfunction

  logic               w_adv;
  fp_class_e          w_ca;
  fp_class_e          w_cb;
  fp_class_e          w_kind;
  logic [EW2-1:0]     w_esum;
  logic [PW-1:0]      w_prod;
  logic [W-1:0]       w_y;
  logic [FLG_W-1:0]   w_fl;

  logic               r_v1;
  fp_class_e          r_k1;
  logic               r_s1;
  logic [EW2-1:0]     r_e1;
  logic [MAN_W:0]     r_ma1;
  logic [MAN_W:0]     r_mb1;
  logic               r_rm1;

  logic               r_v2;
  fp_class_e          r_k2;
  logic               r_s2;
  logic [EW2-1:0]     r_e2;
  logic [PW-1:0]      r_p2;
  logic               r_rm2;

  logic               r_ov;
  logic [W-1:0]       r_y;
  logic [FLG_W-1:0]   r_fl;

  assign w_adv     = !r_ov || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_ov;
  assign y         = r_y;
  assign flags     = r_fl;

  assign w_ca = cls_of(a[W-2:MAN_W], a[MAN_W-1:0]);
  assign w_cb = cls_of(b[W-2:MAN_W], b[MAN_W-1:0]);

  always_comb begin
    if (w_ca == NAN || w_cb == NAN
        || (w_ca == INF && w_cb == ZERO)
        || (w_ca == ZERO && w_cb == INF))
      w_kind = NAN;
    else if (w_ca == INF || w_cb == INF)
      w_kind = INF;
    else if (w_ca == ZERO || w_cb == ZERO)
      w_kind = ZERO;
    else
      w_kind = NORM;
  end

  assign w_esum = {2'b00, a[W-2:MAN_W]}
                + {2'b00, b[W-2:MAN_W]}
                - BIAS;

  assign w_prod = {{(MAN_W+1){1'b0}}, r_ma1}
                * {{(MAN_W+1){1'b0}}, r_mb1};

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .i_prod  (r_p2),
    .i_exp   (r_e2),
    .i_sign  (r_s2),
    .i_rnd   (r_rm2),
    .i_kind  (r_k2),
    .o_y     (w_y),
    .o_flags (w_fl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_k1  <= ZERO;
      r_s1  <= 1'b0;
      r_e1  <= '0;
      r_ma1 <= '0;
      r_mb1 <= '0;
      r_rm1 <= 1'b0;
      r_v2  <= 1'b0;
      r_k2  <= ZERO;
      r_s2  <= 1'b0;
      r_e2  <= '0;
      r_p2  <= '0;
      r_rm2 <= 1'b0;
      r_ov  <= 1'b0;
      r_y   <= '0;
      r_fl  <= '0;
    end else if (w_adv) begin
      r_v1  <= in_valid;
      r_k1  <= w_kind;
      r_s1  <= a[W-1] ^ b[W-1];
      r_e1  <= w_esum;
      r_ma1 <= {1'b1, a[MAN_W-1:0]};
      r_mb1 <= {1'b1, b[MAN_W-1:0]};
      r_rm1 <= rnd_mode;
      r_v2  <= r_v1;
      r_k2  <= r_k1;
      r_s2  <= r_s1;
      r_e2  <= r_e1;
      r_p2  <= w_prod;
      r_rm2 <= r_rm1;
      r_ov  <= r_v2;
      // Only real results overwrite the output so y/flags stay put.
      if (r_v2) begin
        r_y  <= w_y;
        r_fl <= w_fl;
      end
    end
  end

endmodule
